// File: rtl/ysyx_23060208_ifu_fetch.sv
// rtl/ysyx_23060208_ifu_fetch.sv - NPC instruction fetch unit, one instruction in flight
// Fetches a word, hands {pc, inst} to decode, then waits for the resolved next PC.
module ysyx_23060208_ifu_fetch #(
  parameter int unsigned           DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = 32'h8000_0000
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  output logic                      inst_req_valid_o,
  input  logic                      inst_req_ready_i,
  output logic [DATA_WIDTH-1:0]     inst_req_addr_o,
  input  logic                      inst_resp_valid_i,
  input  logic [DATA_WIDTH-1:0]     inst_resp_data_i,
  output logic                      inst_resp_ready_o,
  input  logic                      exu_nextpc_valid_i,
  input  logic [DATA_WIDTH-1:0]     exu_nextpc_i,
  output logic [2*DATA_WIDTH-1:0]   ifu_to_idu_bus_o,
  output logic                      ifu_to_idu_valid_o,
  input  logic                      idu_allowin_i,
  output logic [31:0]               fetch_cnt_o
);

  typedef enum logic [1:0] {
    S_REQ       = 2'd0,
    S_WAIT_RESP = 2'd1,
    S_SEND      = 2'd2,
    S_WAIT_PC   = 2'd3
  } state_e;

  state_e                  state_q, state_d;
  logic [DATA_WIDTH-1:0]   pc_q, pc_d;
  logic [2*DATA_WIDTH-1:0] bus_q, bus_d;
  logic                    pend_valid_q, pend_valid_d;
  logic [DATA_WIDTH-1:0]   pend_pc_q, pend_pc_d;
  logic [31:0]             fetch_cnt_q, fetch_cnt_d;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= S_REQ;
      pc_q         <= RESET_PC;
      bus_q        <= '0;
      pend_valid_q <= 1'b0;
      pend_pc_q    <= '0;
      fetch_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      bus_q        <= bus_d;
      pend_valid_q <= pend_valid_d;
      pend_pc_q    <= pend_pc_d;
      fetch_cnt_q  <= fetch_cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    bus_d        = bus_q;
    pend_valid_d = pend_valid_q;
    pend_pc_d    = pend_pc_q;
    fetch_cnt_d  = fetch_cnt_q;
    case (state_q)
      S_REQ: begin
        if (inst_req_ready_i) state_d = S_WAIT_RESP;
        if (exu_nextpc_valid_i) begin
          pend_valid_d = 1'b1;
          pend_pc_d    = exu_nextpc_i;
        end
      end
      S_WAIT_RESP: begin
        if (inst_resp_valid_i) begin
          bus_d   = {pc_q, inst_resp_data_i};
          state_d = S_SEND;
        end
        if (exu_nextpc_valid_i) begin
          pend_valid_d = 1'b1;
          pend_pc_d    = exu_nextpc_i;
        end
      end
      S_SEND: begin
        if (idu_allowin_i) begin
          fetch_cnt_d = fetch_cnt_q + 32'd1;
          // A live pulse is newer than anything buffered, so it wins.
          if (exu_nextpc_valid_i) begin
            pc_d         = exu_nextpc_i;
            pend_valid_d = 1'b0;
            state_d      = S_REQ;
          end else if (pend_valid_q) begin
            pc_d         = pend_pc_q;
            pend_valid_d = 1'b0;
            state_d      = S_REQ;
          end else begin
            state_d = S_WAIT_PC;
          end
        end else if (exu_nextpc_valid_i) begin
          pend_valid_d = 1'b1;
          pend_pc_d    = exu_nextpc_i;
        end
      end
      S_WAIT_PC: begin
        if (exu_nextpc_valid_i) begin
          pc_d    = exu_nextpc_i;
          state_d = S_REQ;
        end
      end
      default: state_d = S_REQ;
    endcase
  end

  // Handshake outputs stay low for the whole reset cycle, not just after the first edge.
  assign inst_req_valid_o   = !rst_i && (state_q == S_REQ);
  assign inst_resp_ready_o  = !rst_i && (state_q == S_WAIT_RESP);
  assign ifu_to_idu_valid_o = !rst_i && (state_q == S_SEND);
  assign inst_req_addr_o    = {pc_q[DATA_WIDTH-1:2], 2'b00};
  assign ifu_to_idu_bus_o   = bus_q;
  assign fetch_cnt_o        = fetch_cnt_q;

endmodule

// File: tb/tb_ysyx_23060208_ifu_fetch.sv
// tb/tb_ysyx_23060208_ifu_fetch.sv - scoreboard bench for the instruction fetch unit
// Directed fetch sequences push expectations; negedge monitors pop and compare.
module tb_ysyx_23060208_ifu_fetch;

  logic        clk;
  logic        rst;
  logic        inst_req_valid;
  logic        inst_req_ready;
  logic [31:0] inst_req_addr;
  logic        inst_resp_valid;
  logic [31:0] inst_resp_data;
  logic        inst_resp_ready;
  logic        exu_nextpc_valid;
  logic [31:0] exu_nextpc;
  logic [63:0] ifu_to_idu_bus;
  logic        ifu_to_idu_valid;
  logic        idu_allowin;
  logic [31:0] fetch_cnt;

  ysyx_23060208_ifu_fetch dut (
    .clk_i              (clk),
    .rst_i              (rst),
    .inst_req_valid_o   (inst_req_valid),
    .inst_req_ready_i   (inst_req_ready),
    .inst_req_addr_o    (inst_req_addr),
    .inst_resp_valid_i  (inst_resp_valid),
    .inst_resp_data_i   (inst_resp_data),
    .inst_resp_ready_o  (inst_resp_ready),
    .exu_nextpc_valid_i (exu_nextpc_valid),
    .exu_nextpc_i       (exu_nextpc),
    .ifu_to_idu_bus_o   (ifu_to_idu_bus),
    .ifu_to_idu_valid_o (ifu_to_idu_valid),
    .idu_allowin_i      (idu_allowin),
    .fetch_cnt_o        (fetch_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_fail   = 0;
  int n_req = 0, n_deliv = 0, n_push_req = 0, n_push_deliv = 0;
  logic [31:0] q_addr[$];
  logic [63:0] q_bus[$];
  logic [31:0] q_cnt[$];
  logic [31:0] exp_cnt = 32'd0;

  // memory responder controls
  logic        mem_auto = 1'b1;
  logic        stale_valid = 1'b0;
  int          req_wait = 0, resp_wait = 0;
  int          req_cnt = 0, resp_cnt = 0;
  logic [31:0] mem_addr = 32'd0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h expected=%h", name, got, exp);
    end
  endtask

  task automatic fail_timeout(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s actual=timeout expected=event", name);
  endtask

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return {a[15:0], 16'h0413};
  endfunction

  task automatic push_req(input logic [31:0] pc);
    q_addr.push_back({pc[31:2], 2'b00});
    n_push_req++;
  endtask

  task automatic push_fetch(input logic [31:0] pc);
    logic [31:0] a;
    a = {pc[31:2], 2'b00};
    push_req(pc);
    q_bus.push_back({pc, inst_of(a)});
    q_cnt.push_back(exp_cnt);
    exp_cnt = exp_cnt + 32'd1;
    n_push_deliv++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Responder updates after the main stimulus so both see settled DUT outputs.
  initial begin
    inst_req_ready  = 1'b0;
    inst_resp_valid = 1'b0;
    inst_resp_data  = 32'd0;
    forever begin
      @(posedge clk);
      #2;
      if (mem_auto) begin
        if (inst_req_valid) begin
          inst_req_ready = (req_cnt >= req_wait);
          mem_addr = inst_req_addr;
          req_cnt++;
        end else begin
          inst_req_ready = 1'b0;
          req_cnt = 0;
        end
        if (inst_resp_ready) begin
          inst_resp_valid = (resp_cnt >= resp_wait);
          inst_resp_data  = inst_of(mem_addr);
          resp_cnt++;
        end else begin
          inst_resp_valid = 1'b0;
          resp_cnt = 0;
        end
      end else begin
        inst_req_ready  = 1'b0;
        inst_resp_valid = stale_valid;
        inst_resp_data  = 32'hDEAD_BEEF;
        req_cnt = 0;
        resp_cnt = 0;
      end
    end
  end

  // Monitors: request/delivery scoreboard plus hold-while-stalled checks.
  logic        prev_req_stall = 1'b0, prev_send_stall = 1'b0;
  logic [31:0] prev_addr = 32'd0;
  logic [63:0] prev_bus = 64'd0;
  always @(negedge clk) begin
    if (!rst) begin
      if (prev_req_stall && inst_req_valid)
        check("req_addr_hold", 64'(inst_req_addr), 64'(prev_addr));
      if (prev_send_stall) begin
        check("stall_valid_hold", 64'(ifu_to_idu_valid), 64'd1);
        check("stall_bus_hold", ifu_to_idu_bus, prev_bus);
      end
      if (inst_req_valid && inst_req_ready) begin
        n_req++;
        if (q_addr.size() == 0) check("req_unexpected", 64'(inst_req_addr), 64'hFFFF_FFFF_FFFF_FFFF);
        else check("req_addr", 64'(inst_req_addr), 64'(q_addr.pop_front()));
      end
      if (ifu_to_idu_valid && idu_allowin) begin
        n_deliv++;
        if (q_bus.size() == 0) check("deliv_unexpected", ifu_to_idu_bus, 64'hFFFF_FFFF_FFFF_FFFF);
        else begin
          check("deliv_bus", ifu_to_idu_bus, q_bus.pop_front());
          check("deliv_cnt", 64'(fetch_cnt), 64'(q_cnt.pop_front()));
        end
      end
    end
    prev_req_stall  = !rst && inst_req_valid && !inst_req_ready;
    prev_send_stall = !rst && ifu_to_idu_valid && !idu_allowin;
    prev_addr       = inst_req_addr;
    prev_bus        = ifu_to_idu_bus;
  end

  task automatic pulse(input logic [31:0] npc);
    exu_nextpc_valid = 1'b1;
    exu_nextpc = npc;
    tick();
    exu_nextpc_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int k = 0;
    while (q_bus.size() != 0 && k < 60) begin
      tick();
      k++;
    end
    if (q_bus.size() != 0) fail_timeout(name);
  endtask

  task automatic wait_send(input string name);
    int k = 0;
    while (!ifu_to_idu_valid && k < 30) begin
      tick();
      k++;
    end
    if (!ifu_to_idu_valid) fail_timeout(name);
  endtask

  initial begin
    rst = 1'b1;
    exu_nextpc_valid = 1'b0;
    exu_nextpc = 32'd0;
    idu_allowin = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    check("rst_req_valid", 64'(inst_req_valid), 64'd0);
    check("rst_resp_ready", 64'(inst_resp_ready), 64'd0);
    check("rst_idu_valid", 64'(ifu_to_idu_valid), 64'd0);
    check("rst_bus", ifu_to_idu_bus, 64'd0);
    check("rst_cnt", 64'(fetch_cnt), 64'd0);

    // Reset fetch with zero-wait memory
    tick();
    rst = 1'b0;
    push_fetch(32'h8000_0000);
    @(negedge clk);
    check("t1_req_valid", 64'(inst_req_valid), 64'd1);
    check("t1_req_addr", 64'(inst_req_addr), 64'h8000_0000);
    tick();
    @(negedge clk);
    check("t1_resp_ready", 64'(inst_resp_ready), 64'd1);
    tick();
    @(negedge clk);
    check("t1_send_valid", 64'(ifu_to_idu_valid), 64'd1);
    check("t1_bus", ifu_to_idu_bus, 64'h8000_0000_0000_0413);
    tick();
    @(negedge clk);
    check("t1_cnt", 64'(fetch_cnt), 64'd1);
    check("t1_wait_pc", 64'(ifu_to_idu_valid | inst_req_valid), 64'd0);

    // nextpc in WAIT_PC: REQ at N+1, WAIT_RESP at N+2, SEND at N+3
    tick();
    push_fetch(32'h8000_0008);
    pulse(32'h8000_0008);
    @(negedge clk);
    check("lat_req", 64'(inst_req_valid), 64'd1);
    tick();
    @(negedge clk);
    check("lat_resp", 64'(inst_resp_ready), 64'd1);
    tick();
    @(negedge clk);
    check("lat_send", 64'(ifu_to_idu_valid), 64'd1);
    drain("lat_drain");

    // Memory backpressure
    req_wait = 5;
    resp_wait = 3;
    push_fetch(32'h8000_0020);
    pulse(32'h8000_0020);
    drain("bp_drain");
    req_wait = 0;
    resp_wait = 0;

    // Decode stall with early nextpc
    idu_allowin = 1'b0;
    push_fetch(32'h8000_0030);
    pulse(32'h8000_0030);
    wait_send("stall_wait_send");
    tick();
    push_fetch(32'h8000_0010);
    pulse(32'h8000_0010);
    @(negedge clk);
    check("stall_valid", 64'(ifu_to_idu_valid), 64'd1);
    check("stall_bus", ifu_to_idu_bus, {32'h8000_0030, inst_of(32'h8000_0030)});
    tick();
    idu_allowin = 1'b1;
    tick();
    @(negedge clk);
    check("stall_skip_req", 64'(inst_req_valid), 64'd1);
    check("stall_skip_addr", 64'(inst_req_addr), 64'h8000_0010);
    drain("stall_drain");

    // Same-cycle handoff and nextpc
    push_fetch(32'h8000_0060);
    pulse(32'h8000_0060);
    wait_send("same_wait_send");
    push_fetch(32'h8000_0100);
    pulse(32'h8000_0100);
    @(negedge clk);
    check("same_req", 64'(inst_req_valid), 64'd1);
    check("same_addr", 64'(inst_req_addr), 64'h8000_0100);
    drain("same_drain");

    // Misaligned redirect
    push_fetch(32'h8000_0006);
    pulse(32'h8000_0006);
    drain("mis_drain");
    check("mis_bus_pc", 64'(ifu_to_idu_bus[63:32]), 64'h8000_0006);

    // Reset in WAIT_RESP, then a stale response
    resp_wait = 100;
    push_req(32'h8000_0040);
    pulse(32'h8000_0040);
    begin
      int k = 0;
      while (!inst_resp_ready && k < 20) begin
        tick();
        k++;
      end
      if (!inst_resp_ready) fail_timeout("mid_wait_resp");
    end
    tick();
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_req", 64'(inst_req_valid), 64'd0);
    check("mid_rst_resp", 64'(inst_resp_ready), 64'd0);
    tick();
    rst = 1'b0;
    mem_auto = 1'b0;
    stale_valid = 1'b1;
    exp_cnt = 32'd0;
    @(negedge clk);
    check("mid_cnt", 64'(fetch_cnt), 64'd0);
    check("mid_addr", 64'(inst_req_addr), 64'h8000_0000);
    for (int i = 0; i < 3; i++) begin
      tick();
      @(negedge clk);
      check("stale_ignored", 64'({inst_req_valid, inst_resp_ready, ifu_to_idu_valid}), 64'b100);
    end
    tick();
    mem_auto = 1'b1;
    stale_valid = 1'b0;
    resp_wait = 0;
    push_fetch(32'h8000_0000);
    drain("mid_drain");
    check("mid_cnt_after", 64'(fetch_cnt), 64'd1);

    // Counter wrap
    force dut.fetch_cnt_q = 32'hFFFF_FFFF;
    tick();
    release dut.fetch_cnt_q;
    @(negedge clk);
    check("wrap_preload", 64'(fetch_cnt), 64'hFFFF_FFFF);
    exp_cnt = 32'hFFFF_FFFF;
    tick();
    push_fetch(32'h8000_0050);
    pulse(32'h8000_0050);
    drain("wrap_drain");
    @(negedge clk);
    check("wrap_cnt", 64'(fetch_cnt), 64'd0);

    repeat (2) tick();
    check("req_total", 64'(n_req), 64'(n_push_req));
    check("deliv_total", 64'(n_deliv), 64'(n_push_deliv));
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
